// File: rtl/filtro_sensores.sv
// Input conditioning for the irrigation controller: two-flop synchroniser, per-channel
// stability filter gated by a sample strobe, and water-level code validation with fault latch.
module filtro_sensores #(
  parameter int ESTAVEL_CICLOS = 4,
  parameter int FALHA_CICLOS   = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       amostra,
  input  logic       umidadeAr,
  input  logic       umidadeSolo,
  input  logic       temperatura,
  input  logic [2:0] nivelDagua,
  output logic       umidadeArFilt,
  output logic       umidadeSoloFilt,
  output logic       temperaturaFilt,
  output logic [2:0] nivelFilt,
  output logic       falhaSensor,
  output logic       atualizado
);

  localparam logic [3:0] EST_N = 4'(ESTAVEL_CICLOS);
  localparam logic [3:0] FAL_N = 4'(FALHA_CICLOS);

  typedef enum logic [1:0] {
    ESTAVEL,
    CONFIRMANDO,
    INVALIDO
  } estado_t;

  logic [5:0] sync1_q, sync1_d;
  logic [5:0] sync2_q, sync2_d;
  logic [2:0] bin_filt_q, bin_filt_d;
  logic [3:0] bin_cnt_q [3];
  logic [3:0] bin_cnt_d [3];
  estado_t    estado_q, estado_d;
  logic [2:0] nivel_q, nivel_d;
  logic [2:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] falha_cnt_q, falha_cnt_d;
  logic       falha_q, falha_d;
  logic       atualizado_q, atualizado_d;

  logic [2:0] smp_nivel;
  logic       smp_valido;
  logic       trata_valido;

  // Thermometer level codes: only contiguous ones from the bottom are physical.
  function automatic logic nivel_valido(input logic [2:0] c);
    return (c == 3'b000) || (c == 3'b001) || (c == 3'b011) || (c == 3'b111);
  endfunction

  always_comb begin
    sync1_d = {nivelDagua, temperatura, umidadeSolo, umidadeAr};
    sync2_d = sync1_q;
  end

  assign smp_nivel  = sync2_q[5:3];
  assign smp_valido = nivel_valido(smp_nivel);

  always_comb begin
    bin_filt_d = bin_filt_q;
    for (int i = 0; i < 3; i++) begin
      bin_cnt_d[i] = bin_cnt_q[i];
      if (amostra) begin
        if (sync2_q[i] == bin_filt_q[i]) begin
          bin_cnt_d[i] = '0;
        end else if (bin_cnt_q[i] + 4'd1 == EST_N) begin
          bin_filt_d[i] = sync2_q[i];
          bin_cnt_d[i]  = '0;
        end else begin
          bin_cnt_d[i] = bin_cnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    estado_d     = estado_q;
    nivel_d      = nivel_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    falha_cnt_d  = falha_cnt_q;
    falha_d      = falha_q;
    trata_valido = 1'b0;
    if (amostra) begin
      case (estado_q)
        CONFIRMANDO: begin
          if (!smp_valido) begin
            estado_d    = INVALIDO;
            cnt_d       = '0;
            falha_cnt_d = 4'd1;
            if (FAL_N == 4'd1) falha_d = 1'b1;
          end else if (smp_nivel == cand_q) begin
            if (cnt_q + 4'd1 == EST_N) begin
              nivel_d  = cand_q;
              falha_d  = 1'b0;
              cnt_d    = '0;
              estado_d = ESTAVEL;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (smp_nivel == nivel_q) begin
            estado_d = ESTAVEL;
            cnt_d    = '0;
          end else begin
            cand_d = smp_nivel;
            cnt_d  = 4'd1;
          end
        end
        INVALIDO: begin
          if (!smp_valido) begin
            if (falha_cnt_q < FAL_N) falha_cnt_d = falha_cnt_q + 4'd1;
            if (falha_cnt_d == FAL_N) falha_d = 1'b1;
          end else begin
            falha_cnt_d  = '0;
            trata_valido = 1'b1;
          end
        end
        default: begin
          if (!smp_valido) begin
            estado_d    = INVALIDO;
            cnt_d       = '0;
            falha_cnt_d = 4'd1;
            if (FAL_N == 4'd1) falha_d = 1'b1;
          end else begin
            trata_valido = 1'b1;
          end
        end
      endcase
      // A valid sample seen from rest (or right after bad codes) starts a fresh confirmation.
      if (trata_valido) begin
        if (smp_nivel == nivel_q) begin
          estado_d = ESTAVEL;
          cnt_d    = '0;
        end else if (EST_N == 4'd1) begin
          nivel_d  = smp_nivel;
          falha_d  = 1'b0;
          estado_d = ESTAVEL;
          cnt_d    = '0;
        end else begin
          cand_d   = smp_nivel;
          cnt_d    = 4'd1;
          estado_d = CONFIRMANDO;
        end
      end
    end
  end

  // Fault-flag transitions alone never pulse atualizado.
  assign atualizado_d = (bin_filt_d != bin_filt_q) || (nivel_d != nivel_q);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      bin_filt_q   <= '0;
      for (int i = 0; i < 3; i++) bin_cnt_q[i] <= '0;
      estado_q     <= ESTAVEL;
      nivel_q      <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      falha_cnt_q  <= '0;
      falha_q      <= 1'b0;
      atualizado_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      bin_filt_q   <= bin_filt_d;
      for (int i = 0; i < 3; i++) bin_cnt_q[i] <= bin_cnt_d[i];
      estado_q     <= estado_d;
      nivel_q      <= nivel_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      falha_cnt_q  <= falha_cnt_d;
      falha_q      <= falha_d;
      atualizado_q <= atualizado_d;
    end
  end

  assign umidadeArFilt   = bin_filt_q[0];
  assign umidadeSoloFilt = bin_filt_q[1];
  assign temperaturaFilt = bin_filt_q[2];
  assign nivelFilt       = nivel_q;
  assign falhaSensor     = falha_q;
  assign atualizado      = atualizado_q;

endmodule

// File: tb/tb_filtro_sensores.sv
// Bench for filtro_sensores: directed strobe-period table, hand-written reset sequences,
// and randomized stimulus compared every clock against a sample-history reference model.
module tb_filtro_sensores;

  localparam int EST = 4;
  localparam int FAL = 6;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       amostra = 1'b0;
  logic       umidadeAr = 1'b0;
  logic       umidadeSolo = 1'b0;
  logic       temperatura = 1'b0;
  logic [2:0] nivelDagua = 3'b000;
  logic       umidadeArFilt, umidadeSoloFilt, temperaturaFilt;
  logic [2:0] nivelFilt;
  logic       falhaSensor, atualizado;

  int n_checks = 0;
  int n_err = 0;

  filtro_sensores #(.ESTAVEL_CICLOS(EST), .FALHA_CICLOS(FAL)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .amostra(amostra),
    .umidadeAr(umidadeAr),
    .umidadeSolo(umidadeSolo),
    .temperatura(temperatura),
    .nivelDagua(nivelDagua),
    .umidadeArFilt(umidadeArFilt),
    .umidadeSoloFilt(umidadeSoloFilt),
    .temperaturaFilt(temperaturaFilt),
    .nivelFilt(nivelFilt),
    .falhaSensor(falhaSensor),
    .atualizado(atualizado)
  );

  always #5 clock = ~clock;

  // Output vector layout: {ar, solo, temp, nivel[2:0], falha, atualizado}
  logic [7:0] dut_vec;
  assign dut_vec = {umidadeArFilt, umidadeSoloFilt, temperaturaFilt, nivelFilt, falhaSensor, atualizado};

  // Reference model: a channel commits once its last EST strobe samples all agree on a
  // new (valid) value; the fault sets once the last FAL strobe samples were all invalid.
  logic [5:0] m_s1 = '0, m_s2 = '0;
  logic [2:0] m_bin = '0;
  logic [2:0] m_niv = '0;
  logic       m_falha = 1'b0, m_atu = 1'b0;
  logic [5:0] m_hist[$];

  function automatic bit codigo_ok(input logic [2:0] c);
    return c == 3'b000 || c == 3'b001 || c == 3'b011 || c == 3'b111;
  endfunction

  task automatic model_update();
    logic [2:0] prev_bin;
    logic [2:0] prev_niv;
    logic [2:0] v;
    bit todos;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_bin = '0; m_niv = '0; m_falha = 1'b0; m_atu = 1'b0;
      m_hist.delete();
      return;
    end
    prev_bin = m_bin;
    prev_niv = m_niv;
    if (amostra) begin
      m_hist.push_back(m_s2);
      if (m_hist.size() > 16) void'(m_hist.pop_front());
      for (int b = 0; b < 3; b++) begin
        if (m_hist.size() >= EST) begin
          todos = 1'b1;
          for (int k = 0; k < EST; k++)
            if (m_hist[m_hist.size() - 1 - k][b] == prev_bin[b]) todos = 1'b0;
          if (todos) m_bin[b] = ~prev_bin[b];
        end
      end
      v = m_s2[5:3];
      if (m_hist.size() >= EST && codigo_ok(v) && v != m_niv) begin
        todos = 1'b1;
        for (int k = 0; k < EST; k++)
          if (m_hist[m_hist.size() - 1 - k][5:3] != v) todos = 1'b0;
        if (todos) begin
          m_niv = v;
          m_falha = 1'b0;
        end
      end
      if (m_hist.size() >= FAL) begin
        todos = 1'b1;
        for (int k = 0; k < FAL; k++)
          if (codigo_ok(m_hist[m_hist.size() - 1 - k][5:3])) todos = 1'b0;
        if (todos) m_falha = 1'b1;
      end
    end
    m_atu = (m_bin != prev_bin) || (m_niv != prev_niv);
    m_s2 = m_s1;
    m_s1 = {nivelDagua, temperatura, umidadeSolo, umidadeAr};
  endtask

  task automatic check(input string nome, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at t=%0t", nome, got, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clock);
    model_update();
    @(negedge clock);
    check("ciclo", dut_vec, {m_bin[0], m_bin[1], m_bin[2], m_niv, m_falha, m_atu});
  endtask

  // One strobe period: raw values applied, strobe on the 4th clock (after sync delay).
  task automatic periodo(input logic ar, input logic solo, input logic temp, input logic [2:0] niv);
    umidadeAr = ar; umidadeSolo = solo; temperatura = temp; nivelDagua = niv;
    amostra = 1'b0;
    repeat (3) tick();
    amostra = 1'b1;
    tick();
    amostra = 1'b0;
  endtask

  typedef struct {
    logic       ar, solo, temp;
    logic [2:0] niv;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic ar, input logic solo, input logic temp, input logic [2:0] niv,
                     input logic e_ar, input logic e_solo, input logic e_temp, input logic [2:0] e_niv,
                     input logic e_f, input logic e_atu);
    vec_t r;
    r.ar = ar; r.solo = solo; r.temp = temp; r.niv = niv;
    r.exp = {e_ar, e_solo, e_temp, e_niv, e_f, e_atu};
    vecs.push_back(r);
  endtask

  initial begin
    repeat (3) add(1, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    add(1, 0, 0, 3'b000, 1, 0, 0, 3'b000, 0, 1);
    repeat (3) add(1, 1, 0, 3'b000, 1, 0, 0, 3'b000, 0, 0);
    add(1, 0, 0, 3'b000, 1, 0, 0, 3'b000, 0, 0);
    repeat (3) add(1, 1, 0, 3'b000, 1, 0, 0, 3'b000, 0, 0);
    add(1, 1, 0, 3'b000, 1, 1, 0, 3'b000, 0, 1);
    repeat (2) add(1, 1, 0, 3'b001, 1, 1, 0, 3'b000, 0, 0);
    repeat (3) add(1, 1, 0, 3'b011, 1, 1, 0, 3'b000, 0, 0);
    add(1, 1, 0, 3'b011, 1, 1, 0, 3'b011, 0, 1);
    repeat (5) add(1, 1, 0, 3'b101, 1, 1, 0, 3'b011, 0, 0);
    add(1, 1, 0, 3'b101, 1, 1, 0, 3'b011, 1, 0);
    repeat (3) add(1, 1, 0, 3'b111, 1, 1, 0, 3'b011, 1, 0);
    add(1, 1, 0, 3'b111, 1, 1, 0, 3'b111, 0, 1);
    repeat (3) add(1, 1, 1, 3'b001, 1, 1, 0, 3'b111, 0, 0);
    add(1, 1, 1, 3'b001, 1, 1, 1, 3'b001, 0, 1);
    repeat (5) add(1, 1, 1, 3'b010, 1, 1, 1, 3'b001, 0, 0);
    add(1, 1, 1, 3'b010, 1, 1, 1, 3'b001, 1, 0);
    add(1, 1, 1, 3'b001, 1, 1, 1, 3'b001, 1, 0);
    repeat (2) add(1, 1, 1, 3'b000, 1, 1, 1, 3'b001, 1, 0);
    add(1, 1, 1, 3'b110, 1, 1, 1, 3'b001, 1, 0);
    repeat (3) add(0, 1, 1, 3'b000, 1, 1, 1, 3'b001, 1, 0);
    add(0, 1, 1, 3'b000, 0, 1, 1, 3'b000, 0, 1);

    // Reset dominates a held strobe with every raw input high.
    reset_n = 1'b0; amostra = 1'b1;
    umidadeAr = 1'b1; umidadeSolo = 1'b1; temperatura = 1'b1; nivelDagua = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset", dut_vec, 8'b0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pos_reset_espera", dut_vec, 8'b0);
    end
    tick();
    check("pos_reset_commit", dut_vec, {3'b111, 3'b111, 1'b0, 1'b1});
    tick();
    check("pos_reset_pulso", dut_vec, {3'b111, 3'b111, 1'b0, 1'b0});

    reset_n = 1'b0; amostra = 1'b0;
    umidadeAr = 1'b0; umidadeSolo = 1'b0; temperatura = 1'b0; nivelDagua = 3'b000;
    repeat (2) tick();
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      periodo(vecs[i].ar, vecs[i].solo, vecs[i].temp, vecs[i].niv);
      check($sformatf("vetor%0d", i), dut_vec, vecs[i].exp);
    end

    // Reset in the middle of a level confirmation restarts the count.
    repeat (3) periodo(0, 1, 1, 3'b011);
    check("meio_confirmacao", dut_vec, {3'b011, 3'b000, 1'b0, 1'b0});
    reset_n = 1'b0;
    tick();
    check("reset_meio", dut_vec, 8'b0);
    reset_n = 1'b1;
    repeat (3) periodo(0, 1, 1, 3'b011);
    check("recontagem", dut_vec, 8'b0);
    periodo(0, 1, 1, 3'b011);
    check("recontagem_commit", dut_vec, {3'b011, 3'b011, 1'b0, 1'b1});

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) umidadeAr = ~umidadeAr;
      if ($urandom_range(0, 11) == 0) umidadeSolo = ~umidadeSolo;
      if ($urandom_range(0, 11) == 0) temperatura = ~temperatura;
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0) nivelDagua = 3'($urandom_range(0, 7));
        else begin
          case ($urandom_range(0, 3))
            0: nivelDagua = 3'b000;
            1: nivelDagua = 3'b001;
            2: nivelDagua = 3'b011;
            default: nivelDagua = 3'b111;
          endcase
        end
      end
      amostra = (c >= 3000) ? 1'b1 : ($urandom_range(0, 2) == 0);
      reset_n = ($urandom_range(0, 799) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
